upstream_request_controller: RTL and testbench

Front-end stage of the cache write path. It buffers incoming write requests in a small FIFO and hands each one to the downstream memory-update FSM through an `ack` pulse. It then performs the memory write and signals completion to the downstream FSM with a `memwr` pulse. It is the producer of the `ack`/`memwr` pair that the downstream processor consumes, and it observes that processor's busy output.

---
 rtl/upstream_request_controller.sv | 186 ++++++++++++++++++
 tb/tb_upstream_request_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upstream_request_controller.sv
// upstream_request_controller
// Front-end of the cache write path. Incoming write requests are queued in a
// small FIFO; each one is announced to the downstream memory-update FSM with an
// ack pulse, written to memory once downstream reports busy, and closed with a
// memwr pulse. A transaction whose downstream never goes busy is aborted after
// TIMEOUT cycles and flagged in the sticky err_timeout bit.
module upstream_request_controller #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_data,
   output logic                          ack,
   input  logic                          ds_busy,
   output logic                          mem_wr_en,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_gnt,
   output logic                          memwr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_timeout
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACK     = 3'd1,
      WAIT_DS = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t              state;
   state_t              next_state;

   logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                ready_en;
   logic                push;
   logic                pop;

   logic [TMO_W-1:0]    tmo_cnt;
   logic                tmo_hit;
   logic                tmo_clr;
   logic                tmo_inc;
   logic                set_err;
   logic                illegal;

   // ready_en keeps req_ready low while in reset and for the first edge after it
   assign req_ready  = ready_en && (count < DEPTH_C);
   assign push       = req_valid && req_ready;
   assign fifo_count = count;
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and state-decoded outputs; a pop happens only when leaving IDLE
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      set_err    = 1'b0;
      illegal    = 1'b0;
      ack        = 1'b0;
      memwr      = 1'b0;
      mem_wr_en  = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && !ds_busy) begin
               next_state = ACK;
               pop        = 1'b1;
            end
         end
         ACK: begin
            ack        = 1'b1;
            tmo_clr    = 1'b1;
            next_state = WAIT_DS;
         end
         WAIT_DS: begin
            if (ds_busy) begin
               next_state = WRITE;
            end else if (tmo_hit) begin
               set_err    = 1'b1;
               next_state = IDLE;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         WRITE: begin
            mem_wr_en = 1'b1;
            if (mem_gnt) begin
               next_state = DONE;
            end
         end
         DONE: begin
            memwr      = 1'b1;
            next_state = IDLE;
         end
         default: begin
            illegal    = 1'b1;
            next_state = IDLE;
         end
      endcase
   end

   // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_data[wr_ptr] <= req_data;
      end
   end

   // Transaction datapath: head entry latched on pop, wait counter, sticky abort flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr    <= '0;
         mem_wdata   <= '0;
         tmo_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (pop) begin
            mem_addr  <= fifo_addr[rd_ptr];
            mem_wdata <= fifo_data[rd_ptr];
         end else if (illegal) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
         end
         if (tmo_clr || illegal) begin
            tmo_cnt <= '0;
         end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
         if (set_err) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_upstream_request_controller.sv
// Self-checking bench for upstream_request_controller. A negedge monitor plays
// the downstream FSM and the memory, and checks every granted write against a
// scoreboard of expected (addr, data) pairs filled when requests are accepted.
module tb_upstream_request_controller;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_data;
   logic                ack;
   logic                ds_busy;
   logic                mem_wr_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_gnt;
   logic                memwr;
   logic [CNT_W-1:0]    fifo_count;
   logic                err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic ds_auto;
   logic ds_force;
   logic auto_busy;
   int   gnt_delay;
   int   gnt_cnt;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [ADDR_W+DATA_W-1:0] exp_e;

   int ack_count = 0;
   int memwr_count = 0;
   int write_count = 0;
   int viol = 0;
   int last_ack_cyc, last_memwr_cyc, wr_start_cyc, err_cyc, last_accept;
   int wr_len, last_wr_len;
   logic wr_prev, err_prev;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;

   assign ds_busy = ds_auto ? auto_busy : ds_force;

   upstream_request_controller #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .ack         (ack),
      .ds_busy     (ds_busy),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .memwr       (memwr),
      .fifo_count  (fifo_count),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Cycle index, advanced on every active edge
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream FSM and memory model plus scoreboard checking of granted writes
   always @(negedge clk) begin
      if (!rst_n) begin
         auto_busy = 1'b0;
         mem_gnt   = 1'b0;
         gnt_cnt   = 0;
         wr_prev   = 1'b0;
         err_prev  = 1'b0;
      end else begin
         if (ack && memwr) viol++;
         if (ack) begin
            ack_count++;
            last_ack_cyc = cyc;
         end
         if (memwr) begin
            memwr_count++;
            last_memwr_cyc = cyc;
         end
         if (err_timeout && !err_prev) err_cyc = cyc;
         err_prev = err_timeout;
         if (ds_auto) begin
            if (ack) auto_busy = 1'b1;
            else if (memwr) auto_busy = 1'b0;
         end
         if (mem_wr_en) begin
            if (!wr_prev) begin
               wr_start_cyc = cyc;
               wr_len       = 0;
               hold_addr    = mem_addr;
               hold_data    = mem_wdata;
            end else if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
               viol++;
            end
            wr_len++;
            mem_gnt = (gnt_cnt >= gnt_delay);
            gnt_cnt++;
            if (mem_gnt) begin
               write_count++;
               last_wr_len = wr_len;
               checkOutput("write_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  exp_e = exp_q.pop_front();
                  checkOutput("wr_addr", 64'(mem_addr), 64'(exp_e[ADDR_W+DATA_W-1:DATA_W]));
                  checkOutput("wr_data", 64'(mem_wdata), 64'(exp_e[DATA_W-1:0]));
               end
            end
         end else begin
            mem_gnt = 1'b0;
            gnt_cnt = 0;
         end
         wr_prev = mem_wr_en;
      end
   end

   // Offer one request (called at a negedge) and wait for it to be accepted
   task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input bit expect_write);
      int n;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checkOutput("push_accept", 64'(req_ready), 64'(1));
         req_valid = 1'b0;
         return;
      end
      if (expect_write) exp_q.push_back({a, d});
      @(negedge clk);
      last_accept = cyc;
      req_valid = 1'b0;
   endtask

   task automatic waitWrites(input int target, input int budget);
      int n;
      n = 0;
      while (write_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_writes", 64'(write_count), 64'(target));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int a0, m0, w0, acc_t, n;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
      ds_auto = 1'b0; ds_force = 1'b0; gnt_delay = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", 64'(ack), 64'(0));
      checkOutput("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
      checkOutput("rst_fifo_count", 64'(fifo_count), 64'(0));
      checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
      checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
      checkOutput("rst_err", 64'(err_timeout), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", 64'(req_ready), 64'(1));

      $display("[TB] single request");
      ds_auto = 1'b1;
      a0 = ack_count; m0 = memwr_count; w0 = write_count;
      applyStimulus(16'h0040, 32'hDEADBEEF, 1'b1);
      waitWrites(w0 + 1, 40);
      checkOutput("single_acks", 64'(ack_count - a0), 64'(1));
      checkOutput("single_memwr", 64'(memwr_count - m0), 64'(1));
      checkOutput("single_wr_len", 64'(last_wr_len), 64'(1));
      checkOutput("lat_ack", 64'(last_ack_cyc - last_accept), 64'(1));
      checkOutput("lat_wr", 64'(wr_start_cyc - last_accept), 64'(3));
      checkOutput("lat_memwr", 64'(last_memwr_cyc - last_accept), 64'(4));
      checkOutput("single_count", 64'(fifo_count), 64'(0));

      $display("[TB] memory backpressure");
      gnt_delay = 7;
      m0 = memwr_count; w0 = write_count;
      applyStimulus(16'h1234, 32'hCAFEF00D, 1'b1);
      waitWrites(w0 + 1, 60);
      gnt_delay = 0;
      checkOutput("bp_wr_len", 64'(last_wr_len), 64'(8));
      checkOutput("bp_memwr", 64'(memwr_count - m0), 64'(1));
      checkOutput("bp_memwr_lat", 64'(last_memwr_cyc - wr_start_cyc), 64'(8));

      $display("[TB] fill and drain");
      ds_auto = 1'b0; ds_force = 1'b1;
      w0 = write_count;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'(16'h0100 + i * 16), 32'hA000_0000 + 32'(i), 1'b1);
      end
      checkOutput("full_count", 64'(fifo_count), 64'(4));
      checkOutput("full_ready", 64'(req_ready), 64'(0));
      req_valid = 1'b1; req_addr = 16'h0140; req_data = 32'hA000_0004;
      exp_q.push_back({req_addr, req_data});
      repeat (3) @(negedge clk);
      checkOutput("fifth_held", 64'(fifo_count), 64'(4));
      ds_auto = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("fifth_ready", 64'(req_ready), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      waitWrites(w0 + 5, 200);
      checkOutput("drain_count", 64'(fifo_count), 64'(0));

      $display("[TB] push/pop collision");
      ds_auto = 1'b0; ds_force = 1'b1;
      w0 = write_count;
      applyStimulus(16'h0200, 32'h1111_0000, 1'b1);
      applyStimulus(16'h0210, 32'h1111_0001, 1'b1);
      checkOutput("coll_pre_count", 64'(fifo_count), 64'(2));
      req_valid = 1'b1; req_addr = 16'h0220; req_data = 32'h1111_0002;
      exp_q.push_back({req_addr, req_data});
      ds_force = 1'b0; ds_auto = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("coll_ack", 64'(ack), 64'(1));
      checkOutput("coll_count", 64'(fifo_count), 64'(2));
      waitWrites(w0 + 3, 120);

      $display("[TB] timeout");
      ds_auto = 1'b0; ds_force = 1'b0;
      m0 = memwr_count; w0 = write_count;
      checkOutput("err_before", 64'(err_timeout), 64'(0));
      applyStimulus(16'h0BAD, 32'h0BAD_BAD0, 1'b0);
      acc_t = last_accept;
      applyStimulus(16'h0600, 32'h6060_6060, 1'b1);
      n = 0;
      while (!err_timeout && n < 30) begin
         @(negedge clk);
         n++;
      end
      ds_auto = 1'b1;
      waitWrites(w0 + 1, 60);
      checkOutput("err_set", 64'(err_timeout), 64'(1));
      checkOutput("err_latency", 64'(err_cyc - acc_t), 64'(6));
      checkOutput("tmo_memwr", 64'(memwr_count - m0), 64'(1));
      checkOutput("tmo_count", 64'(fifo_count), 64'(0));

      $display("[TB] reset mid-write");
      gnt_delay = 100;
      m0 = memwr_count; w0 = write_count;
      applyStimulus(16'h0700, 32'h7000_0000, 1'b0);
      applyStimulus(16'h0710, 32'h7000_0001, 1'b0);
      applyStimulus(16'h0720, 32'h7000_0002, 1'b0);
      n = 0;
      while (!mem_wr_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pre_rst_wr_en", 64'(mem_wr_en), 64'(1));
      checkOutput("pre_rst_count", 64'(fifo_count), 64'(2));
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_wr_en", 64'(mem_wr_en), 64'(0));
      checkOutput("mid_rst_ack", 64'(ack), 64'(0));
      checkOutput("mid_rst_memwr", 64'(memwr), 64'(0));
      checkOutput("mid_rst_count", 64'(fifo_count), 64'(0));
      checkOutput("mid_rst_ready", 64'(req_ready), 64'(0));
      gnt_delay = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", 64'(req_ready), 64'(1));
      checkOutput("post_rst_err", 64'(err_timeout), 64'(0));
      repeat (10) @(negedge clk);
      checkOutput("post_rst_writes", 64'(write_count - w0), 64'(0));
      checkOutput("post_rst_memwr", 64'(memwr_count - m0), 64'(0));
      checkOutput("post_rst_count", 64'(fifo_count), 64'(0));

      checkOutput("invariants", 64'(viol), 64'(0));
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the bench always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
